// File: rtl/counter_defs_pkg.sv
// Shared constants for the up/down counter family, plus the elaboration-time
// width sanity check used by every counter instance.
package counter_defs;
    localparam int CNT_WRAP = 0;
    localparam int CNT_SAT  = 1;
endpackage

`ifndef COUNTER_DEFS_WIDTH_CHECK
`define COUNTER_DEFS_WIDTH_CHECK
`define CNT_WIDTH_CHECK(W, M) \
    if ((W) < 2 || ((64'(M)) >> (W)) != 0) begin : g_width_check \
        $error("counter: WIDTH must be >= 2 and MAX_VAL < 2**WIDTH"); \
    end
`endif

// File: rtl/param_updown_counter_adder.sv
// Ripple-carry adder built from a chain of one-bit full-adder cells.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module ripple_carry_adder #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CIN,
    output logic [WIDTH-1:0] S,
    output logic             COUT
);
    logic [WIDTH:0] c;

    assign c[0] = CIN;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        full_adder u_fa (
            .a (A[i]),
            .b (B[i]),
            .ci(c[i]),
            .s (S[i]),
            .co(c[i+1])
        );
    end

    assign COUT = c[WIDTH];
endmodule

// File: rtl/param_updown_counter.sv
// Up/down counter with programmable step, load and modulus; wraps or
// saturates at the boundary and flags boundary events on tc/ovf.
module param_updown_counter
    import counter_defs::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}},
    parameter int               SATURATE = CNT_WRAP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic [WIDTH-1:0] step,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf
);
    localparam int           W1   = WIDTH + 1;
    localparam logic [W1-1:0] MAXX = {1'b0, MAX_VAL};
    localparam logic [W1-1:0] MODX = MAXX + W1'(1);

    `CNT_WIDTH_CHECK(WIDTH, MAX_VAL)

    logic [WIDTH-1:0] s_cl, ld_cl, nxt;
    logic [W1-1:0]    add_b, sum1, corr_b, sum2;
    logic             co1, co2, evt;
    logic             unused_sum2_hi;

    assign s_cl  = (step > MAX_VAL) ? MAX_VAL : step;
    assign ld_cl = (load_val > MAX_VAL) ? MAX_VAL : load_val;

    // Down counting is count + ~s + 1; carry out low means a borrow.
    assign add_b = up ? {1'b0, s_cl} : ~{1'b0, s_cl};

    ripple_carry_adder #(.WIDTH(W1)) u_step (
        .A   ({1'b0, count}),
        .B   (add_b),
        .CIN (~up),
        .S   (sum1),
        .COUT(co1)
    );

    // Modulus correction: subtract on up-wrap, add back on down-borrow.
    // When counting up, its carry out is exactly the sum >= MODX test.
    assign corr_b = up ? ~MODX : MODX;

    ripple_carry_adder #(.WIDTH(W1)) u_wrap (
        .A   (sum1),
        .B   (corr_b),
        .CIN (up),
        .S   (sum2),
        .COUT(co2)
    );

    assign unused_sum2_hi = sum2[WIDTH];

    always_comb begin
        nxt = count;
        evt = 1'b0;
        if (s_cl == '0) begin
            nxt = count;
        end else if (SATURATE == CNT_SAT) begin
            if (up) begin
                if (sum1 >= MAXX) begin
                    nxt = MAX_VAL;
                    evt = (count != MAX_VAL);
                end else begin
                    nxt = sum1[WIDTH-1:0];
                end
            end else if (!co1 || sum1[WIDTH-1:0] == '0) begin
                nxt = '0;
                evt = (count != '0);
            end else begin
                nxt = sum1[WIDTH-1:0];
            end
        end else if (up ? co2 : !co1) begin
            nxt = sum2[WIDTH-1:0];
            evt = 1'b1;
        end else begin
            nxt = sum1[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            tc    <= 1'b0;
            ovf   <= 1'b0;
        end else if (load) begin
            count <= ld_cl;
            tc    <= 1'b0;
            ovf   <= ovf & ~clr_ovf;
        end else if (en) begin
            count <= nxt;
            tc    <= evt;
            ovf   <= evt | (ovf & ~clr_ovf);
        end else begin
            tc    <= 1'b0;
            ovf   <= ovf & ~clr_ovf;
        end
    end
endmodule

// File: tb/tb_param_updown_counter.sv
// Drives four counter configurations from shared stimulus and compares each
// against an arithmetic reference model, plus directed boundary checks.
module tb_param_updown_counter;
    logic        clk = 1'b0;
    logic        rst, en, up, load, clr_ovf;
    logic [31:0] step, load_val;

    logic [7:0]  cnt_a;
    logic [3:0]  cnt_b, cnt_c;
    logic [31:0] cnt_d;
    logic        tc_a, tc_b, tc_c, tc_d;
    logic        ovf_a, ovf_b, ovf_c, ovf_d;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    param_updown_counter #(.WIDTH(8)) u_a (
        .clk(clk), .rst(rst), .en(en), .up(up), .step(step[7:0]), .load(load),
        .load_val(load_val[7:0]), .clr_ovf(clr_ovf), .count(cnt_a), .tc(tc_a), .ovf(ovf_a));
    param_updown_counter #(.WIDTH(4), .MAX_VAL(4'd9)) u_b (
        .clk(clk), .rst(rst), .en(en), .up(up), .step(step[3:0]), .load(load),
        .load_val(load_val[3:0]), .clr_ovf(clr_ovf), .count(cnt_b), .tc(tc_b), .ovf(ovf_b));
    param_updown_counter #(.WIDTH(4), .MAX_VAL(4'd12), .SATURATE(1)) u_c (
        .clk(clk), .rst(rst), .en(en), .up(up), .step(step[3:0]), .load(load),
        .load_val(load_val[3:0]), .clr_ovf(clr_ovf), .count(cnt_c), .tc(tc_c), .ovf(ovf_c));
    param_updown_counter #(.WIDTH(32)) u_d (
        .clk(clk), .rst(rst), .en(en), .up(up), .step(step), .load(load),
        .load_val(load_val), .clr_ovf(clr_ovf), .count(cnt_d), .tc(tc_d), .ovf(ovf_d));

    // Reference model: one entry per instance above.
    int     mw[4]   = '{8, 4, 4, 32};
    longint mmax[4] = '{255, 9, 12, 64'hFFFF_FFFF};
    bit     msat[4] = '{0, 0, 1, 0};
    longint mc[4]   = '{0, 0, 0, 0};
    bit     mt[4]   = '{0, 0, 0, 0};
    bit     mo[4]   = '{0, 0, 0, 0};

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic longint got_cnt(int i);
        case (i)
            0:       return longint'(cnt_a);
            1:       return longint'(cnt_b);
            2:       return longint'(cnt_c);
            default: return longint'(cnt_d);
        endcase
    endfunction

    function automatic longint got_tc(int i);
        case (i)
            0:       return longint'(tc_a);
            1:       return longint'(tc_b);
            2:       return longint'(tc_c);
            default: return longint'(tc_d);
        endcase
    endfunction

    function automatic longint got_ovf(int i);
        case (i)
            0:       return longint'(ovf_a);
            1:       return longint'(ovf_b);
            2:       return longint'(ovf_c);
            default: return longint'(ovf_d);
        endcase
    endfunction

    task automatic model_upd();
        for (int i = 0; i < 4; i++) begin
            longint mask, s, lv, n;
            bit ev;
            mask = (longint'(1) << mw[i]) - 1;
            s    = longint'(step) & mask;
            lv   = longint'(load_val) & mask;
            if (s > mmax[i]) s = mmax[i];
            if (lv > mmax[i]) lv = mmax[i];
            ev = 0;
            if (rst) begin
                mc[i] = 0; mt[i] = 0; mo[i] = 0;
            end else if (load) begin
                mc[i] = lv; mt[i] = 0; mo[i] = mo[i] & ~clr_ovf;
            end else if (en) begin
                n = up ? mc[i] + s : mc[i] - s;
                if (msat[i]) begin
                    if (up && n >= mmax[i]) begin ev = (mc[i] != mmax[i]); n = mmax[i]; end
                    if (!up && n <= 0)      begin ev = (mc[i] != 0);       n = 0;       end
                end else begin
                    if (n > mmax[i]) begin n -= mmax[i] + 1; ev = 1; end
                    if (n < 0)       begin n += mmax[i] + 1; ev = 1; end
                end
                mc[i] = n; mt[i] = ev; mo[i] = ev | (mo[i] & ~clr_ovf);
            end else begin
                mt[i] = 0; mo[i] = mo[i] & ~clr_ovf;
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_upd();
        #1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("model_cnt%0d", i), got_cnt(i), mc[i]);
            chk($sformatf("model_tc%0d", i),  got_tc(i),  longint'(mt[i]));
            chk($sformatf("model_ovf%0d", i), got_ovf(i), longint'(mo[i]));
        end
    endtask

    initial begin
        rst = 1; en = 1; up = 1; step = 5; load = 0; load_val = 0; clr_ovf = 0;
        cyc(); cyc();
        chk("rst_cnt", longint'(cnt_a), 0);
        chk("rst_tc",  longint'(tc_a), 0);
        chk("rst_ovf", longint'(ovf_a), 0);
        rst = 0;
        cyc(); chk("run_cnt5", longint'(cnt_a), 5);
        cyc(); chk("run_cnt10", longint'(cnt_a), 10);
        cyc(); chk("run_cnt15", longint'(cnt_a), 15);

        load = 1; load_val = 7; clr_ovf = 1; cyc();
        load = 0; clr_ovf = 0; up = 1; step = 4; cyc();
        chk("wrapup_cnt", longint'(cnt_b), 1);
        chk("wrapup_tc",  longint'(tc_b), 1);
        chk("wrapup_ovf", longint'(ovf_b), 1);
        cyc();
        chk("wrapup2_cnt", longint'(cnt_b), 5);
        chk("wrapup2_tc",  longint'(tc_b), 0);
        chk("wrapup2_ovf", longint'(ovf_b), 1);

        load = 1; load_val = 2; clr_ovf = 1; cyc();
        load = 0; clr_ovf = 0; up = 0; step = 5; cyc();
        chk("wrapdn_cnt", longint'(cnt_b), 7);
        chk("wrapdn_tc",  longint'(tc_b), 1);
        clr_ovf = 1; step = 8; cyc();
        chk("wrapdn2_cnt", longint'(cnt_b), 9);
        chk("setwins_ovf", longint'(ovf_b), 1);
        clr_ovf = 0;

        load = 1; load_val = 10; cyc();
        load = 0; up = 1; step = 5; cyc();
        chk("sat_up_cnt", longint'(cnt_c), 12);
        chk("sat_up_tc",  longint'(tc_c), 1);
        cyc();
        chk("sat_hold_cnt", longint'(cnt_c), 12);
        chk("sat_hold_tc",  longint'(tc_c), 0);
        up = 0; step = 15; cyc();
        chk("sat_dn_cnt", longint'(cnt_c), 0);
        chk("sat_dn_tc",  longint'(tc_c), 1);

        load = 1; load_val = 15; en = 1; cyc();
        chk("ld_clamp_cnt", longint'(cnt_c), 12);
        chk("ld_clamp_tc",  longint'(tc_c), 0);
        rst = 1; cyc();
        chk("rst_ld_cnt", longint'(cnt_c), 0);
        rst = 0; load_val = 5; cyc();
        load = 0; step = 0; cyc();
        chk("zstep_cnt", longint'(cnt_c), 5);
        chk("zstep_tc",  longint'(tc_c), 0);

        load = 1; load_val = 32'hFFFF_FFFF; cyc();
        load = 0; up = 1; step = 1; cyc();
        chk("roll_cnt", longint'(cnt_d), 0);
        chk("roll_tc",  longint'(tc_d), 1);

        for (int k = 0; k < 10000; k++) begin
            rst      = ($urandom_range(0, 199) == 0);
            load     = ($urandom_range(0, 19) == 0);
            en       = ($urandom_range(0, 3) != 0);
            up       = 1'($urandom_range(0, 1));
            clr_ovf  = ($urandom_range(0, 7) == 0);
            load_val = $urandom;
            case ($urandom_range(0, 3))
                0:       step = $urandom;
                1:       step = 32'hFFFF_FFFF - $urandom_range(0, 3);
                2:       step = 0;
                default: step = $urandom_range(1, 20);
            endcase
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
